// File: rtl/prog_mem_pkg.sv
// Shared types and defaults for the loadable program memory.
package prog_mem_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int ADDR_W_DEF = 11;
    localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = 14'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DONE
    } state_e;

endpackage

// File: rtl/prog_mem_array.sv
// Single-port synchronous RAM; contents are intentionally not reset.
module prog_mem_array #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 2048,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory with host load port, read-back checksum verify and
// core fetch port that is held off while a load is in flight.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2048,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              cpu_hold,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_word,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_csum,
    output logic              ld_done,
    output logic              load_ok,
    output logic              load_err,
    output logic [ADDR_W:0]   ld_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] wsum_q, wsum_d;
    logic [DATA_W-1:0] rsum_q, rsum_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              rvld_q, rvld_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              fvalid_q, fvalid_d;
    logic              fsrc_q, fsrc_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;

    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W:0]   wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rsum_acc;
    logic              pass;

    prog_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ld_word),
        .rdata (ram_rdata)
    );

    assign wr_addr  = {1'b0, base_q} + cnt_q;
    assign rd_addr  = AW'(base_q) + AW'(idx_q);
    assign rsum_acc = rsum_q + (rvld_q ? ram_rdata : '0);
    assign pass     = (rsum_acc == wsum_q) && (wsum_q == csum_q);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wsum_d   = wsum_q;
        rsum_d   = rsum_q;
        csum_d   = csum_q;
        rvld_d   = 1'b0;
        ok_d     = ok_q;
        err_d    = err_q;
        count_d  = count_q;
        ram_we   = 1'b0;
        ram_addr = AW'(fetch_addr);
        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    base_d  = ld_base;
                    cnt_d   = '0;
                    wsum_d  = '0;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                ram_addr = AW'(wr_addr);
                if (ld_valid) begin
                    if (wr_addr < DEPTH_L) begin
                        ram_we = 1'b1;
                        wsum_d = wsum_q + ld_word;
                        cnt_d  = cnt_q + 1'b1;
                        if (ld_last) begin
                            csum_d  = ld_csum;
                            idx_d   = '0;
                            rsum_d  = '0;
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        // out of range: drop the beat and fail the load
                        ok_d    = 1'b0;
                        err_d   = 1'b1;
                        count_d = cnt_q;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_VERIFY: begin
                ram_addr = rd_addr;
                rsum_d   = rsum_acc;
                rvld_d   = idx_q < cnt_q;
                idx_d    = idx_q + 1'b1;
                if (idx_q == cnt_q) begin
                    ok_d    = pass;
                    err_d   = !pass;
                    count_d = cnt_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // fdata_q shadows whatever is on fetch_data so it holds between fetches
    always_comb begin
        fvalid_d = fetch_req;
        fsrc_d   = fetch_req && (state_q == ST_IDLE)
                   && ({1'b0, fetch_addr} < DEPTH_L);
        fdata_d  = fetch_data;
        if (fetch_req && !fsrc_d) begin
            fdata_d = NOP_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            wsum_q   <= '0;
            rsum_q   <= '0;
            csum_q   <= '0;
            rvld_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            fvalid_q <= 1'b0;
            fsrc_q   <= 1'b0;
            fdata_q  <= NOP_WORD;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wsum_q   <= wsum_d;
            rsum_q   <= rsum_d;
            csum_q   <= csum_d;
            rvld_q   <= rvld_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            count_q  <= count_d;
            fvalid_q <= fvalid_d;
            fsrc_q   <= fsrc_d;
            fdata_q  <= fdata_d;
        end
    end

    assign fetch_data  = fsrc_q ? ram_rdata : fdata_q;
    assign fetch_valid = fvalid_q;
    assign cpu_hold    = state_q != ST_IDLE;
    assign ld_ready    = state_q == ST_LOAD;
    assign ld_done     = state_q == ST_DONE;
    assign load_ok     = ok_q;
    assign load_err    = err_q;
    assign ld_count    = count_q;

endmodule
